// File: rtl/pulse_train_analyzer.sv
// Pulse train analyzer: counts pulses from a pad, measures first high width and latest gap, flags end of train.
// Latency: pad edge seen 2-3 cycles later; every result field updates one cycle after the detected event.
// Backpressure: none; results are held in DONE until the next arm or reset.
module pulse_train_analyzer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         pulse_in,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic         done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // lcnt value in the cycle whose increment would reach TIMEOUT
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(TIMEOUT - 1);

  // Input conditioning
  logic s1, s2, s3;
  logic rise, fall;

  // Arm request conditioning
  logic arm_lvl, arm_prev, arm_pulse;

  // Result and working registers
  state_t           state;
  logic [7:0]       pcnt;
  logic [CNT_W-1:0] hw;
  logic [CNT_W-1:0] gap;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic             hw_vld;
  logic             ovf;
  logic             done_r;
  logic             busy_r;

  logic [2:0]       exp_cnt;
  logic             match;

  // Two-flop synchronizer plus one delay flop for edge detection
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Register the enabled arm request and keep the previous level for edge detection
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      arm_lvl  <= 1'b0;
      arm_prev <= 1'b0;
    end else begin
      arm_lvl  <= la_data_in[66] & ~la_oenb[66];
      arm_prev <= arm_lvl;
    end
  end

  assign arm_pulse = arm_lvl & ~arm_prev;

  // Measurement FSM; arm overrides every state and drops a coincident rise
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      pcnt   <= '0;
      hw     <= '0;
      gap    <= '0;
      hcnt   <= '0;
      lcnt   <= '0;
      hw_vld <= 1'b0;
      ovf    <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else if (arm_pulse) begin
      state  <= ST_WAIT_FIRST;
      pcnt   <= '0;
      hw     <= '0;
      gap    <= '0;
      hcnt   <= '0;
      lcnt   <= '0;
      hw_vld <= 1'b0;
      ovf    <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          busy_r <= 1'b0;
        end

        ST_WAIT_FIRST: begin
          // A level already high at arm has no rise, so it is skipped
          if (rise) begin
            pcnt  <= 8'd1;
            hcnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
            state <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            // Only the first pulse's width is reported
            if (!hw_vld) begin
              hw <= hcnt;
            end
            hw_vld <= 1'b1;
            lcnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
            state  <= ST_LOW;
          end else if (s2) begin
            if (hcnt == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end

        ST_LOW: begin
          if (rise) begin
            gap  <= lcnt;
            hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            if (pcnt == 8'hff) begin
              ovf <= 1'b1;
            end else begin
              pcnt <= pcnt + 8'd1;
            end
            state <= ST_HIGH;
          end else if (!s2) begin
            if (lcnt == LOW_LAST) begin
              // Trailing idle ends the train and is not recorded as a gap
              lcnt   <= lcnt + 1'b1;
              done_r <= 1'b1;
              busy_r <= 1'b0;
              state  <= ST_DONE;
            end else if (lcnt == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end

        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Expected count shares the generator's LA field; match only meaningful once done
  assign exp_cnt = la_data_in[63:61];
  assign match   = done_r & (pcnt == {5'd0, exp_cnt});

  // Result word assembly from registered fields
  always_comb begin
    la_data_out        = '0;
    la_data_out[7:0]   = pcnt;
    la_data_out[23:8]  = 16'(hw);
    la_data_out[39:24] = 16'(gap);
    la_data_out[40]    = done_r;
    la_data_out[41]    = match;
    la_data_out[42]    = ovf;
    la_data_out[43]    = busy_r;
  end

  assign done = done_r;

  // LA bits this block does not listen to
  logic unused_la;
  assign unused_la = ^{la_data_in[127:67], la_data_in[65:64], la_data_in[60:0],
                       la_oenb[127:67], la_oenb[65:0]};

endmodule

// File: doc/pulse_train_analyzer.md
# pulse_train_analyzer

Receive-side companion to the LA-controlled pulse generator in the user project area. It samples an external pulse train on a pad input and counts pulses, measuring the first pulse's high width and the inter-pulse gap. It declares the train finished after a programmable idle timeout and reports results and a count-match flag to the management SoC over the logic-analyzer bus. The expected count is read from the same LA field the generator uses for its pulse count, so a loopback self-test is one LA write.

## Interface
Parameters:
- CNT_W, 16, width of the high-width and gap counters (saturating)
- TIMEOUT, 1024, consecutive low cycles that end a train (must be ≥ 2 and < 2^CNT_W)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- pulse_in  in  1  asynchronous pulse train from pad
- la_data_in  in  128  [63:61] expected pulse count EXP; [66] arm request
- la_oenb  in  128  active-low LA enables; bit 66 must be 0 for the arm request to be seen
- la_data_out  out  128  result word, layout below; unused bits 0
- done  out  1  copy of la_data_out[40], for pad/irq use

la_data_out layout:
- [7:0] PCNT: pulses counted, saturates at 255
- [23:8] HW: high width of first pulse in cycles, saturates at 2^CNT_W-1, zero-extended if CNT_W<16
- [39:24] GAP: low width preceding the most recent pulse, same saturation and zero-extension as HW
- [40] DONE
- [41] MATCH: PCNT == EXP, valid while DONE=1
- [42] OVF: any counter saturated
- [43] BUSY: state is WAIT_FIRST, HIGH or LOW

## Operation
- Input conditioning: pulse_in → 2-flop synchronizer (s2) → one delay flop (s3).
  - rise = s2 & ~s3
  - fall = ~s2 & s3
- arm_lvl = la_data_in[66] & ~la_oenb[66], registered. arm_pulse is its 0→1 edge.
- States: IDLE, WAIT_FIRST, HIGH, LOW, DONE.
- arm_pulse in any state:
  - clears PCNT, HW, GAP, OVF, DONE and the internal counters
  - enters WAIT_FIRST on the next cycle
  - has priority over all other transitions
- IDLE: waits for arm_pulse.
- WAIT_FIRST:
  - Ignores a level already high at arm; only a rise counts.
  - On rise: PCNT=1, hcnt=1 → HIGH.
- HIGH:
  - Each cycle with s2=1: hcnt++ (saturating; OVF set on saturation).
  - On fall, first pulse only: HW=hcnt → LOW, lcnt=1.
  - No timeout while high.
- LOW:
  - Each cycle with s2=0: lcnt++.
  - On rise: GAP=lcnt (saturating), PCNT++ (saturating at 255, OVF set), hcnt=1 → HIGH.
  - When lcnt reaches TIMEOUT: → DONE. GAP is unchanged, so the trailing idle is never reported as a gap.
- DONE:
  - DONE=1, BUSY=0, MATCH valid.
  - Holds until arm_pulse or reset; pulse_in is ignored.
- MATCH compares PCNT against EXP as an 8-bit zero-extended value, evaluated combinationally from the registered fields.

## Timing
- Reset (async assert, sync to wb_clk_i on deassert): state IDLE; la_data_out=0; done=0.
- Pin-to-detect latency: an edge on pulse_in is seen as rise/fall 2–3 cycles later, depending on sampling phase.
- Widths are measured on s2, so an N-cycle synchronous high pulse gives HW=N. The minimum resolvable pulse and gap is 1 cycle.
- LA arm path: la_data_in[66] 0→1 → arm_pulse 1 cycle later → BUSY=1 the cycle after that.
- All la_data_out fields are registered.
- A field update caused by an event at cycle t is visible at t+1.
- DONE rises exactly TIMEOUT cycles after the last fall is detected.
- Simultaneous arm_pulse and rise: the arm wins and the rise is dropped. The pulse is not counted.
- Reset mid-train: immediate return to IDLE with all outputs zero; no partial results are retained.

## Test plan
- Loopback burst:
  - Stimulus: EXP=5; arm; drive 5 pulses, each 1 cycle high and 1 cycle low, then hold low.
  - Required: PCNT=5, HW=1, GAP=1, MATCH=1, OVF=0; DONE=1 exactly TIMEOUT cycles after the 5th fall detect.
- Width/gap measurement:
  - Stimulus: arm; pulses of 7 high, 13 low, 3 high.
  - Required: PCNT=2, HW=7 (first pulse only), GAP=13.
- Stuck/preset high:
  - Stimulus: pulse_in high before arm, then low 4 cycles, then high 10 cycles, then low.
  - Required: PCNT=1, HW=10.
  - Stimulus (CNT_W=4): pulse held high 40 cycles.
  - Required: HW=15, OVF=1.
- Mismatch and saturation:
  - Stimulus: EXP=3, 4 pulses.
  - Required: MATCH=0.
  - Stimulus: 300 pulses.
  - Required: PCNT=255, OVF=1.
- Re-arm and reset mid-train:
  - Stimulus: arm during LOW after 2 pulses, then send 1 pulse.
  - Required: PCNT=1.
  - Stimulus: assert wb_rst_i in HIGH.
  - Required: la_data_out=0 on the same edge, state IDLE, later pulses ignored until arm.
- Arm gating:
  - Stimulus: la_data_in[66]=1 with la_oenb[66]=1.
  - Required: BUSY stays 0.
  - Stimulus: clear la_oenb[66] to 0.
  - Required: BUSY=1 two cycles later.
